// File: rtl/audio_mixer.sv
// Four-channel gain/mix engine with saturation and a noise-shaped 4-bit DAC.
// One channel is multiplied per cycle; the product is registered before accumulation.
module audio_mixer (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  input  logic [15:0] wave0,
  input  logic [15:0] wave1,
  input  logic [15:0] wave2,
  input  logic [15:0] wave3,
  input  logic [7:0]  gain0,
  input  logic [7:0]  gain1,
  input  logic [7:0]  gain2,
  input  logic [7:0]  gain3,
  output logic [15:0] mix_out,
  output logic        mix_valid,
  output logic        busy,
  output logic        overrun,
  output logic [3:0]  audio
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    SAT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [3:0][15:0]   w_q;
  logic [3:0][7:0]    g_q;
  logic [1:0]         ch;
  logic               last;
  logic signed [19:0] acc;
  logic signed [19:0] term_q;

  logic signed [15:0] w_s;
  logic signed [24:0] prod;
  logic signed [19:0] term;
  logic [15:0]        sat;
  logic               unused_lsb;

  logic [16:0]        acc17;
  logic [11:0]        err12;

  assign busy = (state != IDLE);

  // Signed product of the selected channel, floored by 7 bits (Q1.7 gain).
  assign w_s        = w_q[ch] ^ 16'h8000;
  assign prod       = w_s * $signed({1'b0, g_q[ch]});
  assign term       = {{2{prod[24]}}, prod[24:7]};
  assign unused_lsb = ^prod[6:0];

  // Clamp the accumulator into the signed 16-bit range.
  always_comb begin
    sat = acc[15:0];
    if (acc > 20'sd32767) begin
      sat = 16'h7FFF;
    end else if (acc < -20'sd32768) begin
      sat = 16'h8000;
    end
  end

  // Next-state logic: one add per cycle, one extra cycle drains the product register.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (sample_tick) state_nx = ACC;
      ACC:  if (last) state_nx = SAT;
      SAT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register and mixing datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      w_q       <= '0;
      g_q       <= '0;
      ch        <= 2'd0;
      last      <= 1'b0;
      acc       <= '0;
      term_q    <= '0;
      mix_out   <= 16'h8000;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      mix_valid <= 1'b0;
      if (sample_tick && state != IDLE) begin
        overrun <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (sample_tick) begin
            w_q    <= {wave3, wave2, wave1, wave0};
            g_q    <= {gain3, gain2, gain1, gain0};
            acc    <= '0;
            term_q <= '0;
            ch     <= 2'd0;
            last   <= 1'b0;
          end
        end
        ACC: begin
          acc    <= acc + term_q;
          term_q <= term;
          if (ch == 2'd3) begin
            last <= 1'b1;
          end else begin
            ch <= ch + 2'd1;
          end
        end
        SAT: begin
          mix_out   <= sat ^ 16'h8000;
          mix_valid <= 1'b1;
          ch        <= 2'd0;
          last      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign acc17 = {1'b0, mix_out} + {5'd0, err12};

  // First-order error-feedback quantiser from 16 bits down to 4.
  always_ff @(posedge clk) begin
    if (rst) begin
      err12 <= 12'd0;
      audio <= 4'h8;
    end else begin
      audio <= acc17[16] ? 4'hF : acc17[15:12];
      err12 <= acc17[16] ? 12'hFFF : acc17[11:0];
    end
  end

endmodule

// File: tb/tb_audio_mixer.sv
// Scoreboard bench for audio_mixer: expected mixes queued at accepted ticks.
// Checks latency, busy/overrun timing, saturation, abort and the DAC duty cycle.
module tb_audio_mixer;

  logic             clk;
  logic             rst;
  logic             sample_tick;
  logic [3:0][15:0] wv;
  logic [3:0][7:0]  gv;
  logic [15:0]      mix_out;
  logic             mix_valid;
  logic             busy;
  logic             overrun;
  logic [3:0]       audio;

  int checks   = 0;
  int failures = 0;

  int cyc      = 0;
  int acc_at   = 0;
  int free_at  = 0;
  bit pending  = 0;
  bit ovr_m    = 0;

  logic [15:0] q[$];

  audio_mixer dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .wave0       (wv[0]),
    .wave1       (wv[1]),
    .wave2       (wv[2]),
    .wave3       (wv[3]),
    .gain0       (gv[0]),
    .gain1       (gv[1]),
    .gain2       (gv[2]),
    .gain3       (gv[3]),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .overrun     (overrun),
    .audio       (audio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_mix(input logic [3:0][15:0] w,
                                            input logic [3:0][7:0] g);
    int s;
    int v;
    int p;
    logic signed [15:0] ws;
    logic [31:0] r;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      ws = w[i] ^ 16'h8000;
      v  = ws;
      p  = v * int'(g[i]);
      s  = s + (p >>> 7);
    end
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    r = s;
    return r[15:0] ^ 16'h8000;
  endfunction

  // Reference timeline: decides which ticks are accepted and queues results.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pending = 0;
      ovr_m   = 0;
      free_at = 0;
      q.delete();
    end else if (sample_tick) begin
      if (cyc >= free_at) begin
        q.push_back(model_mix(wv, gv));
        acc_at  = cyc;
        free_at = cyc + 7;
        pending = 1;
      end else begin
        ovr_m = 1;
      end
    end
  end

  // Output monitor, sampled half a cycle after the active edge.
  always @(negedge clk) begin
    chk("busy", busy, pending && (cyc - acc_at) <= 5);
    chk("overrun", overrun, ovr_m);
    if (pending && cyc == acc_at + 6) begin
      chk("valid", mix_valid, 1);
      pending = 0;
    end
    if (mix_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        chk("mix", mix_out, q.pop_front());
        chk("latency", cyc - acc_at, 6);
      end
    end
  end

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_once();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && pending; i++) @(negedge clk);
    chk("drain", pending, 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_all(input logic [15:0] w, input logic [7:0] g);
    for (int i = 0; i < 4; i++) begin
      wv[i] = w;
      gv[i] = g;
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 4; i++) begin
      wv[i] = 16'($urandom);
      gv[i] = 8'($urandom);
    end
  endtask

  int n9;
  int nbad;

  initial begin
    rst         = 1'b1;
    sample_tick = 1'b0;
    set_all(16'h8000, 8'd128);
    skip(3);
    rst = 1'b0;
    chk("rst_mix_out", mix_out, 16'h8000);
    chk("rst_audio", audio, 4'h8);
    chk("rst_valid", mix_valid, 0);

    tick_once();
    wait_idle();
    chk("midpoint", mix_out, 16'h8000);

    set_all(16'h8000, 8'd128);
    wv[0] = 16'hC000;
    wv[1] = 16'h9000;
    gv[1] = 8'd64;
    tick_once();
    wait_idle();
    chk("two_ch", mix_out, 16'hC800);

    set_all(16'hFFFF, 8'd255);
    tick_once();
    wait_idle();
    chk("sat_hi", mix_out, 16'hFFFF);

    set_all(16'h0000, 8'd255);
    tick_once();
    wait_idle();
    chk("sat_lo", mix_out, 16'h0000);

    for (int n = 0; n < 8; n++) begin
      randomize_inputs();
      tick_once();
      randomize_inputs();
      skip(2);
      randomize_inputs();
      wait_idle();
    end

    randomize_inputs();
    tick_once();
    skip(1);
    randomize_inputs();
    tick_once();
    wait_idle();
    chk("ovr_sticky", overrun, 1);

    pulse_rst();
    chk("ovr_clear", overrun, 0);
    randomize_inputs();
    tick_once();
    skip(5);
    tick_once();
    randomize_inputs();
    tick_once();
    wait_idle();
    chk("ovr_in_sat", overrun, 1);

    pulse_rst();
    randomize_inputs();
    tick_once();
    skip(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_mix", mix_out, 16'h8000);
    chk("abort_audio", audio, 4'h8);
    skip(8);
    chk("abort_no_valid", mix_valid, 0);

    set_all(16'h8000, 8'd128);
    wv[0] = 16'h8800;
    tick_once();
    skip(6);
    chk("dac_mix", mix_out, 16'h8800);
    n9   = 0;
    nbad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (audio == 4'h9) n9++;
      else if (audio != 4'h8) nbad++;
    end
    chk("dac_nines", n9, 8);
    chk("dac_other", nbad, 0);

    skip(2);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_mixer.md
AUDIO_MIXER -- requirements
Module: audio_mixer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk.
REQ-002 SHALL have port clk, input, 1 bit: system clock.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port sample_tick, input, 1 bit: one-cycle strobe that requests one mix.
REQ-005 SHALL have ports wave0..wave3, input, 16 bits each: channel samples, unsigned offset binary, midpoint 0x8000.
REQ-006 SHALL have ports gain0..gain3, input, 8 bits each: unsigned per-channel gain, Q1.7 format, where 128 = 1.0 and 255 = 1.992.
REQ-007 SHALL have port mix_out, output, 16 bits: mixed sample, offset binary, held between mixes.
REQ-008 SHALL have port mix_valid, output, 1 bit: one-cycle pulse when mix_out updates.
REQ-009 SHALL have port busy, output, 1 bit: high while a mix is in progress.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag set by a sample_tick that is ignored.
REQ-011 SHALL have port audio, output, 4 bits: noise-shaped DAC output for the pins.

Function
REQ-012 SHALL implement the states IDLE, ACC and SAT; busy = (state != IDLE).
REQ-013 SHALL, in IDLE on sample_tick=1, snapshot all four waves and gains, clear the 20-bit signed accumulator, set ch=0 and go to ACC.
REQ-014 SHALL, in ACC, add one channel per cycle: term = ((wave_ch ^ 0x8000) as signed 16) * gain_ch, then arithmetic shift right by 7 (floor); each term is sign-extended to 20 bits.
REQ-015 SHALL, in ACC, go to SAT after ch=3 has been added; otherwise increment ch.
REQ-016 SHALL, in SAT, clamp the accumulator to [-32768, 32767], register mix_out = clamped ^ 0x8000, pulse mix_valid, and return to IDLE.
REQ-017 SHALL have a fixed latency: with sample_tick sampled at edge k, mix_out and mix_valid update at edge k+6; mix_valid is high for exactly one cycle; busy is high from edge k+1 until edge k+6.
REQ-018 SHALL ignore a sample_tick that arrives while busy=1, set overrun=1, and leave the running mix unaffected; overrun is cleared only by rst.
REQ-019 SHALL start a new mix from a sample_tick sampled in the same cycle that SAT returns to IDLE only when state==IDLE at that edge; such a tick in SAT counts as an overrun.
REQ-020 SHALL read the inputs only at the snapshot, so changes to wave/gain during ACC do not affect the current result.
REQ-021 SHALL run the DAC every clk cycle on mix_out as follows: acc17 = {0,mix_out} + {0,err12,0000} >> 4 (err12 aligned to bits 11:0).
REQ-022 SHALL, in the DAC, set audio = acc17[16] ? 0xF : acc17[15:12].
REQ-023 SHALL, in the DAC, set err12 = acc17[16] ? 0xFFF : acc17[11:0].
REQ-024 SHALL make the long-run mean of audio*4096 equal mix_out to within one LSB of the 12-bit error.

Reset
REQ-025 SHALL, on rst=1 at an edge, set state=IDLE, ch=0, accumulator=0, mix_out=0x8000, mix_valid=0, overrun=0, err12=0 and audio=0x8.
REQ-026 SHALL abort a mix in progress when rst is asserted during ACC or SAT; no mix_valid pulse follows and mix_out = 0x8000.
REQ-027 SHALL give rst priority over sample_tick in the same cycle.

Verification
REQ-028 SHALL be verified with all waves = 0x8000 and gains = 128, tick at edge k -> mix_valid at k+6, mix_out = 0x8000.
REQ-029 SHALL be verified with wave0 = 0xC000 at gain 128, the others at 0x8000, and wave1 = 0x9000 at gain 64 -> mix_out = 0xC800.
REQ-030 SHALL be verified with all waves = 0xFFFF and gains = 255 -> mix_out = 0xFFFF; and with all waves = 0x0000 and gains = 255 -> mix_out = 0x0000 (saturation).
REQ-031 SHALL be verified with a tick at k and a second tick at k+2 -> a single mix_valid at k+6, overrun = 1, and the result equals the first snapshot.
REQ-032 SHALL be verified with mix_out = 0x8800 held for 16 cycles from err12 = 0 -> audio equals 0x9 in exactly 8 of the 16 cycles and 0x8 in the others.
REQ-033 SHALL be verified with rst asserted at edge k+3 of a mix -> no mix_valid, busy = 0 at k+4, mix_out = 0x8000, audio = 0x8.
